sdm_tx_mod: RTL and testbench

- Parametrised sigma-delta transmitter; successor to the fixed 4-bit/16-pattern table TX.
- Replaces the weight lookup with a true error-feedback modulator: first-order or second-order, selectable at run time.
- Generic sample width, frame length and FIFO depth; no pattern table.
- Sits between a register/DMA write port and the serial pad; pairs with a ones-counting SDM receiver.

---
 rtl/sdm_tx_mod_if.sv | 28 ++
 rtl/sdm_tx_mod.sv | 198 +++++++++++++++++++
 tb/tb_sdm_tx_mod.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdm_tx_mod_if.sv
`default_nettype none
// ============================================================================
// Module : sdm_tx_mod_if
// Brief  : Sample write port and FIFO status of the sigma-delta transmitter.
// Rev    : 1.0
// ============================================================================
interface sdm_tx_mod_if #(
    parameter int DW = 4
);
    logic          push;
    logic [DW-1:0] wdata;
    logic          clear;
    logic          full;
    logic          empty;
    logic          underrun;
    logic          overflow;

    modport master (
        output push, wdata, clear,
        input  full, empty, underrun, overflow
    );

    modport slave (
        input  push, wdata, clear,
        output full, empty, underrun, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sdm_tx_mod.sv
`default_nettype none
// ============================================================================
// Module : sdm_tx_mod
// Brief  : FIFO-fed first/second-order error-feedback sigma-delta transmitter.
// Rev    : 1.0
// ============================================================================
module sdm_tx_mod #(
    parameter int DW       = 4,
    parameter int OSR_LOG2 = 4,
    parameter int AW       = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   setn,
    input  wire logic   en,
    input  wire logic   mode,
    input  wire logic   fclk,
    sdm_tx_mod_if.slave bus,
    output logic        frame,
    output logic [1:0]  cst,
    output logic        tx
);

    localparam int c_N  = 2**OSR_LOG2;
    localparam int c_D  = 2**AW;
    localparam int c_AW = DW + 3;
    localparam int c_VW = DW + 5;
    localparam int c_HI = 2**(DW-1);

    localparam logic signed [c_VW-1:0] c_H    = c_VW'(c_HI);
    localparam logic signed [c_VW-1:0] c_AMAX = c_VW'(4*c_HI - 1);
    localparam logic signed [c_VW-1:0] c_AMIN = c_VW'(-4*c_HI);

    localparam logic [1:0] c_S_IDLE = 2'b00;
    localparam logic [1:0] c_S_RUN  = 2'b10;

    logic                   r_fclk_m, r_fclk_s, r_fclk_d;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [OSR_LOG2-1:0]    r_bc;
    logic [DW-1:0]          r_mem [c_D];
    logic [AW:0]            r_wp, r_rp;
    logic                   r_under, r_over, r_frame, r_tx, r_mode;
    logic signed [DW-1:0]   r_sample;
    logic signed [c_AW-1:0] r_a1, r_a2;

    logic                   w_tick, w_run, w_step, w_load, w_last;
    logic                   w_empty, w_full, w_pop, w_wr, w_drop;
    logic signed [DW-1:0]   w_x;
    logic                   w_mode;
    logic signed [c_AW-1:0] w_a1, w_a2;
    logic signed [c_VW-1:0] w_xe, w_a1e, w_a2e, w_fb;
    logic signed [c_VW-1:0] w_v, w_a1_fo, w_v1, w_v2;
    logic                   w_bit;
    logic signed [c_AW-1:0] w_a1_nxt, w_a2_nxt;

    function automatic logic signed [c_AW-1:0] f_sat(input logic signed [c_VW-1:0] v);
        if (v > c_AMAX)
            return c_AMAX[c_AW-1:0];
        else if (v < c_AMIN)
            return c_AMIN[c_AW-1:0];
        else
            return v[c_AW-1:0];
    endfunction

    // Every fclk transition becomes one single-clk tick.
    assign w_tick  = r_fclk_s ^ r_fclk_d;
    assign w_run   = (r_state == c_S_RUN);
    assign w_step  = setn & w_run & w_tick;
    assign w_load  = w_step & (r_bc == '0);
    assign w_last  = (r_bc == OSR_LOG2'(c_N - 1));

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_pop   = w_load & ~w_empty;
    assign w_wr    = bus.push & (~w_full | w_pop);
    assign w_drop  = bus.push & w_full & ~w_pop;

    // Modulator datapath; a mode change at a frame boundary restarts from zero state.
    always_comb begin
        w_x    = w_load ? (w_empty ? '0 : $signed(r_mem[r_rp[AW-1:0]])) : r_sample;
        w_mode = w_load ? mode : r_mode;
        w_a1   = (w_load && (mode != r_mode)) ? '0 : r_a1;
        w_a2   = (w_load && (mode != r_mode)) ? '0 : r_a2;
        w_xe   = {{5{w_x[DW-1]}}, w_x};
        w_a1e  = {{2{w_a1[c_AW-1]}}, w_a1};
        w_a2e  = {{2{w_a2[c_AW-1]}}, w_a2};
        w_fb   = r_tx ? c_H : -c_H;

        w_v     = w_a1e + w_xe;
        w_a1_fo = w_v - (w_v[c_VW-1] ? -c_H : c_H);

        w_v1 = w_a1e + w_xe - w_fb;
        w_v2 = w_a2e + w_v1 - w_fb;

        w_bit    = 1'b0;
        w_a1_nxt = '0;
        w_a2_nxt = '0;
        if (w_mode) begin
            w_bit    = ~w_v2[c_VW-1];
            w_a1_nxt = f_sat(w_v1);
            w_a2_nxt = f_sat(w_v2);
        end else begin
            w_bit    = ~w_v[c_VW-1];
            w_a1_nxt = w_a1_fo[c_AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_S_IDLE;
        else if (setn)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (en) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (w_step && w_last && !en) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        cst          = r_state;
        frame        = r_frame;
        tx           = r_tx;
        bus.full     = w_full;
        bus.empty    = w_empty;
        bus.underrun = r_under;
        bus.overflow = r_over;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fclk_m <= 1'b0;
            r_fclk_s <= 1'b0;
            r_fclk_d <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_under  <= 1'b0;
            r_over   <= 1'b0;
            r_frame  <= 1'b0;
            r_tx     <= 1'b0;
            r_mode   <= 1'b0;
            r_bc     <= '0;
            r_sample <= '0;
            r_a1     <= '0;
            r_a2     <= '0;
        end else if (setn) begin
            r_fclk_m <= fclk;
            r_fclk_s <= r_fclk_m;
            r_fclk_d <= r_fclk_s;

            if (bus.clear) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_under <= 1'b0;
                r_over  <= 1'b0;
            end else begin
                if (w_wr)
                    r_wp <= r_wp + (AW+1)'(1);
                if (w_pop)
                    r_rp <= r_rp + (AW+1)'(1);
                if (w_drop)
                    r_over <= 1'b1;
                if (w_load && w_empty)
                    r_under <= 1'b1;
            end

            r_frame <= w_load;

            if (!w_run) begin
                r_bc <= '0;
                r_tx <= 1'b0;
                r_a1 <= '0;
                r_a2 <= '0;
            end else if (w_step) begin
                r_bc <= r_bc + OSR_LOG2'(1);
                r_tx <= w_bit;
                r_a1 <= w_a1_nxt;
                r_a2 <= w_a2_nxt;
                if (w_load) begin
                    r_sample <= w_x;
                    r_mode   <= mode;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (setn && w_wr && !bus.clear)
            r_mem[r_wp[AW-1:0]] <= bus.wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_tx_mod.sv
`default_nettype none
// ============================================================================
// Module : tb_sdm_tx_mod
// Brief  : Scoreboard bench for sdm_tx_mod against a behavioural modulator.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sdm_tx_mod;

    localparam int DW       = 4;
    localparam int OSR_LOG2 = 4;
    localparam int AW       = 2;
    localparam int N        = 16;
    localparam int H        = 8;
    localparam int D        = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       setn = 1'b1;
    logic       en   = 1'b0;
    logic       mode = 1'b0;
    logic       fclk = 1'b0;
    logic       frame;
    logic [1:0] cst;
    logic       tx;

    sdm_tx_mod_if #(.DW(DW)) bus ();

    sdm_tx_mod #(.DW(DW), .OSR_LOG2(OSR_LOG2), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .setn  (setn),
        .en    (en),
        .mode  (mode),
        .fclk  (fclk),
        .bus   (bus.slave),
        .frame (frame),
        .cst   (cst),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic tx; logic frame; } exp_t;
    exp_t sb[$];

    int m_fifo[$];
    int m_run, m_bc, m_a1, m_a2, m_tx, m_mode, m_x, m_under, m_over;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 4*H - 1) return 4*H - 1;
        if (v < -4*H)    return -4*H;
        return v;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_run = 0; m_bc = 0; m_a1 = 0; m_a2 = 0; m_tx = 0;
        m_mode = 0; m_x = 0; m_under = 0; m_over = 0;
    endtask

    task automatic model_tick(output bit b, output bit f);
        int v, v1, v2, fb;
        b = 1'b0;
        f = 1'b0;
        if (m_run == 0) return;
        if (m_bc == 0) begin
            f = 1'b1;
            if (m_fifo.size() == 0) begin
                m_x = 0;
                m_under = 1;
            end else begin
                m_x = m_fifo.pop_front();
            end
            if (int'(mode) != m_mode) begin
                m_a1 = 0;
                m_a2 = 0;
            end
            m_mode = int'(mode);
        end
        if (m_mode == 0) begin
            v    = m_a1 + m_x;
            b    = (v >= 0);
            m_a1 = v - (b ? H : -H);
        end else begin
            fb   = m_tx ? H : -H;
            v1   = m_a1 + m_x - fb;
            v2   = m_a2 + v1 - fb;
            b    = (v2 >= 0);
            m_a1 = sat(v1);
            m_a2 = sat(v2);
        end
        m_tx = int'(b);
        m_bc = (m_bc + 1) % N;
        if (m_bc == 0 && !en) begin
            m_run = 0; m_a1 = 0; m_a2 = 0; m_tx = 0;
        end
    endtask

    // Drive one fclk transition; the DUT answers three clocks later.
    task automatic tick(output bit obs);
        exp_t e;
        bit   b, f;
        fclk = ~fclk;
        model_tick(b, f);
        sb.push_back('{tx: b, frame: f});
        repeat (3) @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("tx", int'(tx), int'(e.tx));
        chk("frame", int'(frame), int'(e.frame));
        obs = tx;
        @(negedge clk);
    endtask

    task automatic run_frame(output int ones, output int trans);
        bit b, prev;
        ones  = 0;
        trans = 0;
        prev  = 1'b0;
        for (int i = 0; i < N; i++) begin
            tick(b);
            ones += int'(b);
            if (i > 0 && b != prev) trans++;
            prev = b;
        end
    endtask

    task automatic push_val(input int v);
        bus.push  = 1'b1;
        bus.wdata = v[DW-1:0];
        @(posedge clk);
        if (m_fifo.size() < D) m_fifo.push_back(v);
        else                   m_over = 1;
        @(negedge clk);
        bus.push = 1'b0;
    endtask

    task automatic go();
        en = 1'b1;
        @(posedge clk);
        if (m_run == 0) begin
            m_run = 1; m_bc = 0; m_a1 = 0; m_a2 = 0; m_tx = 0;
        end
        @(negedge clk);
        chk("cst_run", int'(cst), 2);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_empty"}, int'(bus.empty), int'(m_fifo.size() == 0));
        chk({tag, "_full"},  int'(bus.full),  int'(m_fifo.size() == D));
        chk({tag, "_under"}, int'(bus.underrun), m_under);
        chk({tag, "_over"},  int'(bus.overflow), m_over);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, trans;
        bit b;
        int exp5 [5] = '{9, 10, 5, 12, 8};

        bus.push  = 1'b0;
        bus.clear = 1'b0;
        bus.wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", int'(tx), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_cst", int'(cst), 0);
        chk_flags("rst");

        // One sample then an empty FIFO: 3+H ones, then a zero frame with underrun.
        push_val(3);
        go();
        run_frame(ones, trans);
        chk("ones_x3", ones, 11);
        run_frame(ones, trans);
        chk("ones_underrun0", ones, 8);
        chk_flags("f2");

        // Full-scale extremes and mid-scale.
        push_val(-8);
        push_val(7);
        push_val(0);
        run_frame(ones, trans);
        chk("ones_m8", ones, 0);
        run_frame(ones, trans);
        chk("ones_p7", ones, 15);
        run_frame(ones, trans);
        chk("ones_0", ones, 8);
        chk("alt_0", trans, N - 1);

        // en low finishes the current frame, then IDLE ignores ticks.
        en = 1'b0;
        run_frame(ones, trans);
        repeat (2) @(negedge clk);
        chk("cst_idle", int'(cst), 0);
        tick(b);

        // Overflow: fill in IDLE, fifth push dropped.
        push_val(1);
        push_val(2);
        push_val(-3);
        push_val(4);
        chk_flags("fill");
        push_val(5);
        chk_flags("ovf");
        go();
        for (int k = 0; k < 5; k++) begin
            run_frame(ones, trans);
            chk("ones_fifo", ones, exp5[k]);
        end
        chk_flags("drain");

        // clear flushes data and sticky flags; clear beats a coincident push.
        push_val(6);
        bus.clear = 1'b1;
        @(posedge clk);
        m_fifo.delete();
        m_under = 0;
        m_over  = 0;
        @(negedge clk);
        bus.clear = 1'b0;
        chk_flags("clr");
        bus.clear = 1'b1;
        bus.push  = 1'b1;
        bus.wdata = 4'd2;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        chk_flags("clrpush");

        // Second order, idle input.
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_frame(ones, trans);
            chk("o2_zero_range", int'(ones >= 7 && ones <= 9), 1);
        end
        // Second order, near full scale: accumulators clamp instead of wrapping.
        for (int k = 0; k < 4; k++) push_val(7);
        for (int k = 0; k < 4; k++) begin
            run_frame(ones, trans);
            chk("o2_p7_min14", int'(ones >= 14), 1);
        end

        // Freeze mid-frame with an even number of fclk transitions.
        for (int k = 0; k < 5; k++) tick(b);
        setn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fclk = ~fclk;
            repeat (5) @(posedge clk);
            #1;
            chk("frz_tx", int'(tx), m_tx);
            chk("frz_frame", int'(frame), 0);
            @(negedge clk);
        end
        setn = 1'b1;
        for (int k = 0; k < N - 5; k++) tick(b);

        // Asynchronous reset at bit 7 of a frame.
        mode = 1'b0;
        push_val(3);
        for (int k = 0; k < 7; k++) tick(b);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tx", int'(tx), 0);
        chk("arst_frame", int'(frame), 0);
        chk("arst_cst", int'(cst), 0);
        en   = 1'b0;
        fclk = 1'b0;
        model_reset();
        chk_flags("arst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_val(3);
        go();
        run_frame(ones, trans);
        chk("ones_after_rst", ones, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
